// File: rtl/alu_issuer_if.sv
// ---------------------------------------------------------------------------
// alu_issuer_if
// Purpose : bundles the command, ALU-side and response signals of alu_issuer.
// Signals : req_valid/req_ready/req_func/req_a/req_b  - command handshake
//           alu_op/alu_in1/alu_in2/alu_result         - ALU drive and result
//           rsp_valid/rsp_ready/rsp_data/rsp_err      - response handshake
//           rsp_zero                                  - zero flag, present only
//                                                       with ALU_ISSUER_ZFLAG_EN
// Modports: slave  - the issuer block
//           master - the environment (command source, ALU, consumer)
// ---------------------------------------------------------------------------
interface alu_issuer_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_func;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [7:0] alu_op;
   logic [7:0] alu_in1;
   logic [7:0] alu_in2;
   logic [7:0] alu_result;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;
`ifdef ALU_ISSUER_ZFLAG_EN
   logic       rsp_zero;
`endif

   modport slave (
      input  req_valid, req_func, req_a, req_b, alu_result, rsp_ready,
`ifdef ALU_ISSUER_ZFLAG_EN
      output rsp_zero,
`endif
      output req_ready, alu_op, alu_in1, alu_in2, rsp_valid, rsp_data, rsp_err
   );

   modport master (
      output req_valid, req_func, req_a, req_b, alu_result, rsp_ready,
`ifdef ALU_ISSUER_ZFLAG_EN
      input  rsp_zero,
`endif
      input  req_ready, alu_op, alu_in1, alu_in2, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_issuer.sv
// ---------------------------------------------------------------------------
// alu_issuer
// Purpose : accepts one ALU command at a time, drives the opcode and operands
//           to an external registered ALU for one cycle, captures the result
//           and holds it as a response until the consumer takes it.
// Ports   : clk  - system clock, all logic on posedge
//           rst  - synchronous active-high reset
//           bus  - alu_issuer_if.slave (command, ALU and response signals)
// Options : ALU_ISSUER_ZFLAG_EN - adds the registered rsp_zero flag.
// Timing  : accept at edge N -> opcode on alu_op in cycle N+1 -> ALU result
//           valid in cycle N+2 -> rsp_valid from cycle N+3. Illegal functions
//           skip the ALU and respond from cycle N+1 with rsp_err set.
// ---------------------------------------------------------------------------
module alu_issuer (
   input  logic        clk,
   input  logic        rst,
   alu_issuer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     r_state;
   logic       r_req_ready;
   logic [7:0] r_alu_op;
   logic [7:0] r_alu_in1;
   logic [7:0] r_alu_in2;
   logic       r_rsp_valid;
   logic [7:0] r_rsp_data;
   logic       r_rsp_err;
`ifdef ALU_ISSUER_ZFLAG_EN
   logic       r_rsp_zero;
`endif

   logic       w_accept;
   logic       w_legal;
   logic [7:0] w_opcode;

   // Maps a function code to {legal, opcode}; codes 6 and 7 are illegal.
   function automatic logic [8:0] func_to_op(input logic [2:0] func);
      case (func)
         3'd0:    func_to_op = {1'b1, 8'h01};   // ADD
         3'd1:    func_to_op = {1'b1, 8'h02};   // SUB
         3'd2:    func_to_op = {1'b1, 8'h0F};   // AND
         3'd3:    func_to_op = {1'b1, 8'h10};   // OR
         3'd4:    func_to_op = {1'b1, 8'h0E};   // CPL
         3'd5:    func_to_op = {1'b1, 8'h11};   // XOR
         default: func_to_op = {1'b0, 8'h00};
      endcase
   endfunction

   // Decode the offered command and qualify the accept handshake.
   always_comb begin
      w_legal  = 1'b0;
      w_opcode = 8'h00;
      {w_legal, w_opcode} = func_to_op(bus.req_func);
      if (r_state == IDLE) begin
         w_accept = bus.req_valid & r_req_ready;
      end else begin
         w_accept = 1'b0;
      end
   end

   // Issuer FSM; every output is a register updated on the state transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_req_ready <= 1'b1;
         r_alu_op    <= 8'h00;
         r_alu_in1   <= 8'h00;
         r_alu_in2   <= 8'h00;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 8'h00;
         r_rsp_err   <= 1'b0;
`ifdef ALU_ISSUER_ZFLAG_EN
         r_rsp_zero  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  if (w_legal) begin
                     // Operands go straight into the output registers, so the
                     // request inputs are free to change after the accept edge.
                     r_state   <= ISSUE;
                     r_alu_op  <= w_opcode;
                     r_alu_in1 <= bus.req_a;
                     r_alu_in2 <= bus.req_b;
                  end else begin
                     r_state     <= DONE;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= 8'h00;
                     r_rsp_err   <= 1'b1;
`ifdef ALU_ISSUER_ZFLAG_EN
                     r_rsp_zero  <= 1'b0;
`endif
                  end
               end
            end
            ISSUE: begin
               // Opcode 0 tells the ALU to hold its result.
               r_state   <= WAIT;
               r_alu_op  <= 8'h00;
               r_alu_in1 <= 8'h00;
               r_alu_in2 <= 8'h00;
            end
            WAIT: begin
               r_state     <= DONE;
               r_rsp_valid <= 1'b1;
               r_rsp_data  <= bus.alu_result;
               r_rsp_err   <= 1'b0;
`ifdef ALU_ISSUER_ZFLAG_EN
               r_rsp_zero  <= (bus.alu_result == 8'h00);
`endif
            end
            DONE: begin
               // req_ready rises only after the consume edge, so no command
               // can be accepted in the same cycle a response is taken.
               if (bus.rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
               r_alu_op    <= 8'h00;
               r_alu_in1   <= 8'h00;
               r_alu_in2   <= 8'h00;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.alu_op    = r_alu_op;
   assign bus.alu_in1   = r_alu_in1;
   assign bus.alu_in2   = r_alu_in2;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_err   = r_rsp_err;
`ifdef ALU_ISSUER_ZFLAG_EN
   assign bus.rsp_zero  = r_rsp_zero;
`endif

endmodule

// File: tb/tb_alu_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_issuer
// Purpose : self-checking bench for alu_issuer. Contains a registered ALU
//           model on the ALU side and a reference model that derives the
//           expected response directly from the function code and operands.
// Options : honours ALU_ISSUER_ZFLAG_EN for the rsp_zero checks.
// ---------------------------------------------------------------------------
module tb_alu_issuer;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   alu_issuer_if bus ();

   alu_issuer u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Registered ALU model: updates on a nonzero opcode, holds on opcode 0.
   always @(posedge clk) begin
      if (rst) begin
         bus.alu_result <= 8'h00;
      end else begin
         case (bus.alu_op)
            8'h01:   bus.alu_result <= bus.alu_in1 + bus.alu_in2;
            8'h02:   bus.alu_result <= bus.alu_in1 - bus.alu_in2;
            8'h0F:   bus.alu_result <= bus.alu_in1 & bus.alu_in2;
            8'h10:   bus.alu_result <= bus.alu_in1 | bus.alu_in2;
            8'h0E:   bus.alu_result <= ~bus.alu_in1;
            8'h11:   bus.alu_result <= bus.alu_in1 ^ bus.alu_in2;
            default: bus.alu_result <= bus.alu_result;
         endcase
      end
   end

   // Comparison helper: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected response {err, data} computed from the function rules.
   function automatic logic [8:0] ref_rsp(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case (f)
         3'd0:    r = 8'((int'(a) + int'(b)) % 256);
         3'd1:    r = 8'((int'(a) - int'(b) + 256) % 256);
         3'd2:    r = a & b;
         3'd3:    r = a | b;
         3'd4:    r = 8'(255 - int'(a));
         3'd5:    r = a ^ b;
         default: return {1'b1, 8'h00};
      endcase
      return {1'b0, r};
   endfunction

   // Opcode table for the legal functions.
   function automatic logic [7:0] ref_opcode(input logic [2:0] f);
      logic [7:0] tbl [0:5];
      tbl = '{8'h01, 8'h02, 8'h0F, 8'h10, 8'h0E, 8'h11};
      return (f < 3'd6) ? tbl[f] : 8'h00;
   endfunction

   // Follows one command from just after its accept edge to the negedge
   // after its response is consumed, checking every cycle.
   task automatic check_resp(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b, input int hold);
      logic [8:0] exp;
      exp = ref_rsp(f, a, b);
      @(negedge clk);
      if (f < 3'd6) begin
         chk("issue_op", bus.alu_op, ref_opcode(f));
         chk("issue_in1", bus.alu_in1, a);
         chk("issue_in2", bus.alu_in2, b);
         chk("issue_rsp_valid", bus.rsp_valid, 1'b0);
         chk("issue_req_ready", bus.req_ready, 1'b0);
         bus.rsp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("wait_op", bus.alu_op, 8'h00);
         chk("wait_in1", bus.alu_in1, 8'h00);
         chk("wait_rsp_valid", bus.rsp_valid, 1'b0);
         bus.rsp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         bus.rsp_ready = 1'b0;
      end else begin
         chk("illegal_op", bus.alu_op, 8'h00);
      end
      chk("rsp_valid", bus.rsp_valid, 1'b1);
      chk("rsp_data", bus.rsp_data, exp[7:0]);
      chk("rsp_err", bus.rsp_err, exp[8]);
      chk("done_req_ready", bus.req_ready, 1'b0);
`ifdef ALU_ISSUER_ZFLAG_EN
      chk("rsp_zero", bus.rsp_zero, (!exp[8] && exp[7:0] == 8'h00));
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", bus.rsp_valid, 1'b1);
         chk("hold_data", bus.rsp_data, exp[7:0]);
         chk("hold_err", bus.rsp_err, exp[8]);
         chk("hold_req_ready", bus.req_ready, 1'b0);
         chk("hold_op", bus.alu_op, 8'h00);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("consumed_valid", bus.rsp_valid, 1'b0);
      chk("idle_req_ready", bus.req_ready, 1'b1);
   endtask

   // Offers a command from a negedge, waits (bounded) for acceptance, then
   // scrambles or replaces the request inputs and follows the response.
   task automatic send(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b, input int hold,
                       input bit keep, input logic [2:0] nf, input logic [7:0] na, input logic [7:0] nb);
      int waited;
      waited = 0;
      while (bus.req_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (bus.req_ready !== 1'b1) begin
         chk("ready_timeout", bus.req_ready, 1'b1);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_func  = f;
      bus.req_a     = a;
      bus.req_b     = b;
      @(posedge clk);
      #1;
      if (keep) begin
         bus.req_func = nf;
         bus.req_a    = na;
         bus.req_b    = nb;
      end else begin
         bus.req_valid = 1'b0;
         bus.req_func  = 3'($urandom_range(0, 7));
         bus.req_a     = 8'($urandom);
         bus.req_b     = 8'($urandom);
      end
      check_resp(f, a, b, hold);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_func  = 3'd0;
      bus.req_a     = 8'h12;
      bus.req_b     = 8'h34;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // Reset wins over an offered command.
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_alu_op", bus.alu_op, 8'h00);
      chk("rst_alu_in1", bus.alu_in1, 8'h00);
      chk("rst_alu_in2", bus.alu_in2, 8'h00);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_data", bus.rsp_data, 8'h00);
      chk("rst_rsp_err", bus.rsp_err, 1'b0);
`ifdef ALU_ISSUER_ZFLAG_EN
      chk("rst_rsp_zero", bus.rsp_zero, 1'b0);
`endif
      bus.req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // Directed cases.
      send(3'd0, 8'h05, 8'h03, 0, 1'b0, 3'd0, 8'h00, 8'h00);   // ADD -> 08
      send(3'd1, 8'h00, 8'h01, 1, 1'b0, 3'd0, 8'h00, 8'h00);   // SUB wrap -> FF
      send(3'd5, 8'hA5, 8'hA5, 0, 1'b0, 3'd0, 8'h00, 8'h00);   // XOR -> 00
      send(3'd6, 8'h77, 8'h88, 2, 1'b0, 3'd0, 8'h00, 8'h00);   // illegal
      send(3'd7, 8'h01, 8'h02, 0, 1'b0, 3'd0, 8'h00, 8'h00);   // illegal
      send(3'd4, 8'h3C, 8'h00, 5, 1'b0, 3'd0, 8'h00, 8'h00);   // CPL, long hold

      // Back-to-back with req_valid held: AND then OR.
      send(3'd2, 8'hF0, 8'h3C, 2, 1'b1, 3'd3, 8'hF0, 8'h3C);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check_resp(3'd3, 8'hF0, 8'h3C, 1);

      // Reset during WAIT discards the command.
      bus.req_valid = 1'b1;
      bus.req_func  = 3'd0;
      bus.req_a     = 8'h11;
      bus.req_b     = 8'h22;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstwait_req_ready", bus.req_ready, 1'b1);
      chk("rstwait_alu_op", bus.alu_op, 8'h00);
      for (int i = 0; i < 6; i++) begin
         chk("rstwait_no_rsp", bus.rsp_valid, 1'b0);
         @(negedge clk);
      end

      // Randomized commands.
      for (int k = 0; k < 40; k++) begin
         send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
              1'b0, 3'd0, 8'h00, 8'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 The block SHALL have these ports:
  clk          in   1  system clock; all logic on posedge
  rst          in   1  reset, synchronous, active-high
  req_valid    in   1  command offered
  req_ready    out  1  block can accept a command
  req_func     in   3  function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 CPL, 5 XOR, 6-7 illegal
  req_a        in   8  operand A
  req_b        in   8  operand B
  alu_op       out  8  opcode to ALU
  alu_in1      out  8  ALU operand 1
  alu_in2      out  8  ALU operand 2
  alu_result   in   8  ALU registered result
  rsp_valid    out  1  response held
  rsp_ready    in   1  consumer takes response
  rsp_data     out  8  captured result
  rsp_err      out  1  command was illegal
  rsp_zero     out  1  result==0; only with ALU_ISSUER_ZFLAG_EN
REQ-002 Clock SHALL be clk; reset SHALL be rst, synchronous, active-high.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-004 req_ready SHALL be 1 only in IDLE; a command is accepted when req_valid&&req_ready at a posedge.
REQ-005 On accept, req_a, req_b and req_func SHALL be registered, so later input changes are ignored.
REQ-006 func-to-opcode mapping SHALL be: ADD 8'h01, SUB 8'h02, AND 8'h0F, OR 8'h10, CPL 8'h0E, XOR 8'h11.
REQ-007 A legal command SHALL go IDLE->ISSUE; in ISSUE, alu_op, alu_in1 and alu_in2 SHALL carry the mapped opcode, A and B for exactly one cycle.
REQ-008 ISSUE->WAIT unconditionally; at the end of WAIT, alu_result SHALL be captured into rsp_data, then WAIT->DONE.
REQ-009 Outside ISSUE, alu_op SHALL be 8'h00 (ALU holds its value) and alu_in1/alu_in2 SHALL be 8'h00.
REQ-010 An illegal func (6, 7) SHALL go IDLE->DONE directly; rsp_err=1, rsp_data=8'h00 and no ALU opcode is issued.
REQ-011 In DONE, rsp_valid SHALL be 1 and rsp_data/rsp_err stable until rsp_valid&&rsp_ready; then DONE->IDLE.
REQ-012 Latency SHALL be fixed: accept at edge N, alu_op valid in cycle N+1, rsp_valid high from cycle N+3 for a legal op; rsp_valid high from cycle N+1 for an illegal op.
REQ-013 rsp_ready while not in DONE SHALL be ignored.
REQ-014 No new command SHALL be accepted in the cycle a response is consumed; the earliest next accept is the following IDLE cycle.
REQ-015 Arithmetic is performed by the ALU; all data SHALL be 8-bit unsigned with wrap-around, and no carry is reported.

Reset
REQ-016 When rst=1 at a posedge, the state SHALL become IDLE, with req_ready=1 and all other outputs 0, including alu_op=8'h00, rsp_valid=0, rsp_data=0, rsp_err=0 and rsp_zero=0.
REQ-017 rst SHALL take priority over all other inputs; reset mid-operation (ISSUE/WAIT/DONE) SHALL discard the command and produce no response.

Configuration
REQ-018 With ALU_ISSUER_ZFLAG_EN defined, port rsp_zero SHALL exist and SHALL be registered as (alu_result==0) alongside rsp_data (0 for illegal commands).
REQ-019 Without ALU_ISSUER_ZFLAG_EN, rsp_zero SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-020 ADD A=8'h05 B=8'h03 with a behavioural registered ALU model: alu_op=8'h01 for exactly one cycle, then rsp_data=8'h08, rsp_err=0 at N+3.
REQ-021 SUB A=8'h00 B=8'h01 -> rsp_data=8'hFF (wrap); with ZFLAG_EN, XOR A=B=8'hA5 -> rsp_data=8'h00, rsp_zero=1.
REQ-022 func=6 -> rsp_valid at N+1, rsp_err=1, rsp_data=0, and alu_op stays 8'h00 throughout.
REQ-023 Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid/rsp_data stable and req_ready=0; the response is consumed on the first cycle rsp_ready=1.
REQ-024 rst=1 during WAIT -> next cycle IDLE, req_ready=1, rsp_valid never asserts for that command.
REQ-025 Back-to-back AND 8'hF0&8'h3C then OR with req_valid held high -> responses 8'h30 and then 8'hFC in order, with the second accepted only after the first is consumed.
